// File: rtl/axi_dw_upsizer_w_packer_pkg.sv
// Shared AXI burst types, default W channel structs and address helpers
// for the W-channel data-width upsizer.
package axi_dw_upsizer_w_packer_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } pack_state_e;

  localparam int unsigned AddrW     = 16;
  localparam int unsigned UserWidth = 1;

  typedef logic [AddrW-1:0] addr_t;

  typedef struct packed {
    logic [31:0]          data;
    logic [3:0]           strb;
    logic                 last;
    logic [UserWidth-1:0] user;
  } narrow_w_t;

  typedef struct packed {
    logic [255:0]         data;
    logic [31:0]          strb;
    logic                 last;
    logic [UserWidth-1:0] user;
  } wide_w_t;

  function automatic addr_t size_bytes(input logic [2:0] size);
    return addr_t'(1) << size;
  endfunction

  function automatic addr_t aligned_addr(input addr_t addr, input logic [2:0] size);
    return addr & ~(size_bytes(size) - addr_t'(1));
  endfunction

  function automatic addr_t wrap_boundary(input addr_t addr, input logic [2:0] size,
                                          input logic [7:0] len);
    addr_t win;
    win = (addr_t'(len) + addr_t'(1)) << size;
    return addr & ~(win - addr_t'(1));
  endfunction

  // Next beat address of a WRAP burst; falls back to the window start on overflow.
  function automatic addr_t wrap_offset(input addr_t addr, input logic [2:0] size,
                                        input logic [7:0] len);
    addr_t win;
    addr_t bnd;
    addr_t nxt;
    win = (addr_t'(len) + addr_t'(1)) << size;
    bnd = wrap_boundary(addr, size, len);
    nxt = aligned_addr(addr, size) + size_bytes(size);
    if (nxt >= bnd + win) nxt = bnd;
    return nxt;
  endfunction

endpackage

// File: rtl/axi_dw_lane_merge.sv
// Steers one narrow W beat onto the wide byte lanes addressed by offset/size,
// masking strobes outside the transfer window and zeroing unstrobed bytes.
module axi_dw_lane_merge
  import axi_dw_upsizer_w_packer_pkg::*;
#(
  parameter int unsigned SlvDataWidth = 32,
  parameter int unsigned MstDataWidth = 256,
  localparam int unsigned SlvBytes = SlvDataWidth / 8,
  localparam int unsigned MstBytes = MstDataWidth / 8,
  localparam int unsigned OffW     = $clog2(MstBytes)
) (
  input  logic [OffW-1:0]         offset,
  input  logic [2:0]              size,
  input  logic [SlvDataWidth-1:0] slv_data,
  input  logic [SlvBytes-1:0]     slv_strb,
  output logic [MstDataWidth-1:0] mst_data,
  output logic [MstBytes-1:0]     mst_strb
);

  addr_t win_end;

  assign win_end = aligned_addr(addr_t'(offset), size) + size_bytes(size);

  // Wide lane i always pairs with narrow lane i mod SlvBytes (same address bits).
  always_comb begin
    mst_strb = '0;
    mst_data = '0;
    for (int i = 0; i < MstBytes; i++) begin
      mst_strb[i] = (addr_t'(i) >= addr_t'(offset)) && (addr_t'(i) < win_end)
                    && slv_strb[i % SlvBytes];
      mst_data[8*i +: 8] = mst_strb[i] ? slv_data[8*(i % SlvBytes) +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/axi_dw_upsizer_w_packer.sv
// W-channel packer: merges narrow W beats of one burst into wide W beats,
// packing INCR+modifiable bursts and passing others through one beat per beat.
module axi_dw_upsizer_w_packer
  import axi_dw_upsizer_w_packer_pkg::*;
#(
  parameter int unsigned SlvDataWidth = 32,
  parameter int unsigned MstDataWidth = 256,
  parameter type slv_w_chan_t = narrow_w_t,
  parameter type mst_w_chan_t = wide_w_t,
  localparam int unsigned MstBytes = MstDataWidth / 8,
  localparam int unsigned OffW     = $clog2(MstBytes)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [OffW-1:0] cmd_offset_i,
  input  logic [2:0]      cmd_size_i,
  input  logic [7:0]      cmd_len_i,
  input  logic [1:0]      cmd_burst_i,
  input  logic            cmd_modif_i,
  input  slv_w_chan_t     slv_w_i,
  input  logic            slv_w_valid_i,
  output logic            slv_w_ready_o,
  output mst_w_chan_t     mst_w_o,
  output logic            mst_w_valid_o,
  input  logic            mst_w_ready_i,
  output logic            err_o
);

  pack_state_e state_q, state_d;

  logic [OffW-1:0]         offset_q, next_offset;
  logic [2:0]              size_q;
  logic [7:0]              len_q;
  axi_burst_e              burst_q;
  logic [8:0]              remaining_q;
  logic                    pack_q;
  logic [MstDataWidth-1:0] buf_data_q, out_data_q, lane_data;
  logic [MstBytes-1:0]     buf_strb_q, out_strb_q, lane_strb;
  logic [UserWidth-1:0]    out_user_q;
  logic                    out_last_q, out_valid_q, err_q;
  logic                    cmd_fire, beat_fire, last_beat, emit;

  axi_dw_lane_merge #(
    .SlvDataWidth (SlvDataWidth),
    .MstDataWidth (MstDataWidth)
  ) i_lane_merge (
    .offset   (offset_q),
    .size     (size_q),
    .slv_data (slv_w_i.data),
    .slv_strb (slv_w_i.strb),
    .mst_data (lane_data),
    .mst_strb (lane_strb)
  );

  assign cmd_fire  = cmd_valid_i && cmd_ready_o;
  assign beat_fire = slv_w_valid_i && slv_w_ready_o;
  assign last_beat = (remaining_q == 9'd1);
  assign emit      = beat_fire && (last_beat || !pack_q || next_offset == '0);

  always_comb begin
    case (burst_q)
      BURST_FIXED: next_offset = offset_q;
      BURST_WRAP:  next_offset = OffW'(wrap_offset(addr_t'(offset_q), size_q, len_q));
      default:     next_offset = OffW'(aligned_addr(addr_t'(offset_q), size_q)
                                       + size_bytes(size_q));
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_fire) state_d = ST_BURST;
      ST_BURST: if (beat_fire && last_beat) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The output slot must be free (or leaving) before a beat may be merged.
  always_comb begin
    cmd_ready_o   = rst_ni && (state_q == ST_IDLE);
    slv_w_ready_o = rst_ni && (state_q == ST_BURST) && (!out_valid_q || mst_w_ready_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      offset_q    <= '0;
      size_q      <= '0;
      len_q       <= '0;
      burst_q     <= BURST_FIXED;
      remaining_q <= '0;
      pack_q      <= 1'b0;
      buf_data_q  <= '0;
      buf_strb_q  <= '0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= beat_fire && (slv_w_i.last != last_beat);
      if (cmd_fire) begin
        offset_q    <= cmd_offset_i;
        size_q      <= cmd_size_i;
        len_q       <= cmd_len_i;
        burst_q     <= axi_burst_e'(cmd_burst_i);
        remaining_q <= 9'(cmd_len_i) + 9'd1;
        pack_q      <= (cmd_burst_i == BURST_INCR) && cmd_modif_i;
      end
      if (beat_fire) begin
        offset_q    <= next_offset;
        remaining_q <= remaining_q - 9'd1;
        if (emit) begin
          buf_data_q <= '0;
          buf_strb_q <= '0;
        end else begin
          buf_data_q <= buf_data_q | lane_data;
          buf_strb_q <= buf_strb_q | lane_strb;
        end
      end
      if (emit) begin
        out_data_q  <= buf_data_q | lane_data;
        out_strb_q  <= buf_strb_q | lane_strb;
        out_user_q  <= slv_w_i.user;
        out_last_q  <= last_beat;
        out_valid_q <= 1'b1;
      end else if (mst_w_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    mst_w_o      = '0;
    mst_w_o.data = out_data_q;
    mst_w_o.strb = out_strb_q;
    mst_w_o.last = out_last_q;
    mst_w_o.user = out_user_q;
  end

  assign mst_w_valid_o = out_valid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_axi_dw_upsizer_w_packer.sv
// Randomized bench for the W packer with a byte-address reference model.
module tb_axi_dw_upsizer_w_packer;
  import axi_dw_upsizer_w_packer_pkg::*;

  localparam int MST_BYTES = 32;
  localparam int SLV_BYTES = 4;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
    logic         user;
  } wide_exp_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cmd_valid, cmd_ready, cmd_modif;
  logic [4:0]  cmd_offset;
  logic [2:0]  cmd_size;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_burst;
  narrow_w_t   slv_w;
  logic        slv_w_valid, slv_w_ready;
  wide_w_t     mst_w;
  logic        mst_w_valid, mst_w_ready, err;

  int n_vec = 0;
  int n_err = 0;
  int err_cnt = 0;
  bit stall = 0;
  bit rnd_ready = 0;

  logic [31:0] nb_data[256];
  logic [3:0]  nb_strb[256];
  logic        nb_user[256];
  logic        nb_last[256];

  wide_exp_t    exp_q[$];
  logic [31:0]  log_strb[$];
  logic [255:0] log_data[$];
  logic         log_last[$];

  axi_dw_upsizer_w_packer #(
    .SlvDataWidth (32),
    .MstDataWidth (256)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_offset_i  (cmd_offset),
    .cmd_size_i    (cmd_size),
    .cmd_len_i     (cmd_len),
    .cmd_burst_i   (cmd_burst),
    .cmd_modif_i   (cmd_modif),
    .slv_w_i       (slv_w),
    .slv_w_valid_i (slv_w_valid),
    .slv_w_ready_o (slv_w_ready),
    .mst_w_o       (mst_w),
    .mst_w_valid_o (mst_w_valid),
    .mst_w_ready_i (mst_w_ready),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wide-side ready: either always 1, randomly throttled, or forced low.
  initial begin
    mst_w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mst_w_ready = stall ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  always @(negedge clk) begin
    wide_exp_t e;
    if (rst_ni && mst_w_valid && mst_w_ready) begin
      log_strb.push_back(mst_w.strb);
      log_data.push_back(mst_w.data);
      log_last.push_back(mst_w.last);
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("w_data", mst_w.data, e.data);
        check("w_strb", mst_w.strb, e.strb);
        check("w_last", mst_w.last, e.last);
        check("w_user", mst_w.user, e.user);
      end
    end
    if (err) err_cnt++;
  end

  // Reference: each narrow beat lands at its AXI byte address; a packed INCR
  // burst collects beats sharing one wide-word index, otherwise one beat each.
  task automatic model(input logic [1:0] burst, input int len, input int size,
                       input int off, input bit modif);
    int sz, win, bnd, a, word, cur_word, lo;
    bit pack, open;
    wide_exp_t cur;
    sz = 1 << size;
    win = (len + 1) * sz;
    bnd = (off / win) * win;
    pack = (burst == 2'b01) && modif;
    open = 0;
    cur = '0;
    cur_word = 0;
    for (int i = 0; i <= len; i++) begin
      case (burst)
        2'b00:   a = off;
        2'b10:   a = bnd + ((off + i * sz - bnd) % win);
        default: a = (i == 0) ? off : (off / sz) * sz + i * sz;
      endcase
      word = a / MST_BYTES;
      if (open && (!pack || word != cur_word)) begin
        exp_q.push_back(cur);
        open = 0;
      end
      if (!open) begin
        cur = '0;
        open = 1;
        cur_word = word;
      end
      lo = (a / sz) * sz;
      for (int b = a; b < lo + sz; b++) begin
        if (nb_strb[i][b % SLV_BYTES]) begin
          cur.strb[b % MST_BYTES] = 1'b1;
          cur.data[(b % MST_BYTES) * 8 +: 8] = nb_data[i][(b % SLV_BYTES) * 8 +: 8];
        end
      end
      cur.user = nb_user[i];
    end
    cur.last = 1'b1;
    exp_q.push_back(cur);
  endtask

  task automatic drive_cmd(input logic [1:0] burst, input int len, input int size,
                           input int off, input bit modif);
    int t;
    cmd_burst = burst;
    cmd_len = 8'(len);
    cmd_size = 3'(size);
    cmd_offset = 5'(off);
    cmd_modif = modif;
    cmd_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      t++;
      if (t > 200) begin
        check("cmd_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drive_beat(input int i, input bit gaps);
    int g, t;
    g = gaps ? $urandom_range(0, 2) : 0;
    repeat (g) @(posedge clk);
    if (g > 0) #1;
    slv_w.data = nb_data[i];
    slv_w.strb = nb_strb[i];
    slv_w.last = nb_last[i];
    slv_w.user = nb_user[i];
    slv_w_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (slv_w_ready) break;
      t++;
      if (t > 200) begin
        check("beat_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1 slv_w_valid = 1'b0;
  endtask

  task automatic gen_beats(input int len, input bit full_strb, input int bad_last);
    for (int i = 0; i <= len; i++) begin
      nb_data[i] = $urandom;
      nb_strb[i] = (full_strb || $urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      nb_user[i] = 1'($urandom_range(0, 1));
      nb_last[i] = (i == len) || (i == bad_last);
    end
  endtask

  task automatic run_burst(input logic [1:0] burst, input int len, input int size,
                           input int off, input bit modif, input bit gaps,
                           input bit full_strb, input int bad_last);
    gen_beats(len, full_strb, bad_last);
    model(burst, len, size, off, modif);
    drive_cmd(burst, len, size, off, modif);
    for (int i = 0; i <= len; i++) drive_beat(i, gaps);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_strb.delete();
    log_data.delete();
    log_last.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] words;
    logic [255:0] snap;
    int e0, wait_t;

    rst_ni = 1'b0;
    cmd_valid = 1'b0;
    cmd_offset = '0;
    cmd_size = '0;
    cmd_len = '0;
    cmd_burst = '0;
    cmd_modif = 1'b0;
    slv_w = '0;
    slv_w_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_slv_ready", slv_w_ready, 0);
    check("rst_mst_valid", mst_w_valid, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;

    // Full INCR packing into one wide beat.
    clear_logs();
    run_burst(2'b01, 7, 2, 'h00, 1, 0, 1, -1);
    drain();
    for (int i = 0; i < 8; i++) words[32*i +: 32] = nb_data[i];
    check("t1_count", log_strb.size(), 1);
    check("t1_strb", log_strb[0], 32'hFFFF_FFFF);
    check("t1_data", log_data[0], words);
    check("t1_last", log_last[0], 1);

    // INCR crossing the wide boundary.
    clear_logs();
    run_burst(2'b01, 3, 2, 'h18, 1, 0, 1, -1);
    drain();
    check("t2_count", log_strb.size(), 2);
    check("t2_strb0", log_strb[0], 32'hFF00_0000);
    check("t2_strb1", log_strb[1], 32'h0000_00FF);
    check("t2_last0", log_last[0], 0);
    check("t2_last1", log_last[1], 1);

    // FIXED: one wide beat per narrow beat.
    clear_logs();
    run_burst(2'b00, 3, 2, 'h04, 0, 0, 1, -1);
    drain();
    check("t3_count", log_strb.size(), 4);
    for (int i = 0; i < 4 && i < log_strb.size(); i++) begin
      check("t3_strb", log_strb[i], 32'h0000_00F0);
      check("t3_last", log_last[i], (i == 3));
    end

    // Byte-sized INCR at an odd offset.
    clear_logs();
    run_burst(2'b01, 3, 0, 'h01, 1, 0, 1, -1);
    drain();
    check("t4_count", log_strb.size(), 1);
    check("t4_strb", log_strb[0], 32'h0000_001E);
    check("t4_lane1", log_data[0][15:8], nb_data[0][15:8]);
    check("t4_lane4", log_data[0][39:32], nb_data[3][7:0]);

    // Wide backpressure held for 5 cycles mid-burst.
    fork
      run_burst(2'b00, 7, 2, 'h08, 0, 0, 0, -1);
      begin
        repeat (3) @(posedge clk);
        #1 stall = 1;
        wait_t = 0;
        do begin
          @(negedge clk);
          wait_t++;
        end while (!(mst_w_valid && !mst_w_ready) && wait_t < 50);
        check("stall_seen", mst_w_valid && !mst_w_ready, 1);
        snap = mst_w.data;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("stall_data", mst_w.data, snap);
          check("stall_valid", mst_w_valid, 1);
          check("stall_slv_ready", slv_w_ready, 0);
        end
        stall = 0;
      end
    join
    drain();

    // Early last on beat 2: one error pulse, burst still completes.
    clear_logs();
    e0 = err_cnt;
    run_burst(2'b01, 3, 2, 'h00, 1, 0, 1, 1);
    drain();
    repeat (2) @(negedge clk);
    check("err_pulses", err_cnt - e0, 1);
    check("err_count", log_strb.size(), 1);
    check("err_last", log_last[0], 1);
    @(posedge clk);
    #1;

    // Reset after 3 of 8 packed beats drops the partial buffer.
    clear_logs();
    gen_beats(7, 1, -1);
    drive_cmd(2'b01, 7, 2, 'h00, 1);
    for (int i = 0; i < 3; i++) drive_beat(i, 0);
    rst_ni = 1'b0;
    @(negedge clk);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_slv_ready", slv_w_ready, 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("post_rst_valid", mst_w_valid, 0);
    check("post_rst_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    run_burst(2'b01, 0, 2, 'h00, 1, 0, 1, -1);
    drain();
    check("rst_len0_count", log_strb.size(), 1);
    check("rst_len0_last", log_last[0], 1);

    // Random bursts with random gaps and backpressure.
    rnd_ready = 1;
    e0 = err_cnt;
    for (int n = 0; n < 60; n++) begin
      int b, sz, ln, off;
      b = $urandom_range(0, 2);
      sz = $urandom_range(0, 2);
      if (b == 2) ln = (2 << $urandom_range(0, 3)) - 1;
      else ln = $urandom_range(0, 15);
      off = ($urandom_range(0, 31) >> sz) << sz;
      run_burst(2'(b), ln, sz, off, 1'($urandom_range(0, 1)), 1, 0, -1);
    end
    drain();
    rnd_ready = 0;
    repeat (2) @(negedge clk);
    check("rand_no_err", err_cnt - e0, 0);
    check("rand_idle", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
